// File: rtl/warp_inst_queue.sv
// Decoupling instruction queue between the 2-wide fetch unit and decode.
// Optional zero-latency empty-queue bypass enabled by defining WARP_IQ_BYPASS_EN.
module warp_inst_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_valid,
    input  logic [31:0] i_inst0,
    input  logic [31:0] i_inst1,
    input  logic [1:0]  i_compressed,
    input  logic [63:0] i_inst0_pc_rdata,
    input  logic [63:0] i_inst0_pc_wdata,
    input  logic [63:0] i_inst1_pc_rdata,
    input  logic [63:0] i_inst1_pc_wdata,
    output logic        o_stall,
    input  logic        i_flush,
    input  logic        i_stall,
    output logic [1:0]  o_valid,
    output logic [31:0] o_inst0,
    output logic [31:0] o_inst1,
    output logic [1:0]  o_compressed,
    output logic [63:0] o_inst0_pc_rdata,
    output logic [63:0] o_inst0_pc_wdata,
    output logic [63:0] o_inst1_pc_rdata,
    output logic [63:0] o_inst1_pc_wdata
);

    localparam int              CNT_W         = PTR_W + 1;
    localparam logic [31:0]     CANONICAL_NOP = 32'h00000013;
    localparam logic [CNT_W-1:0] STALL_LEVEL  = CNT_W'(DEPTH - 2);
    localparam logic [CNT_W-1:0] CNT_TWO      = CNT_W'(2);

    logic [31:0]      r_inst  [DEPTH];
    logic             r_comp  [DEPTH];
    logic [63:0]      r_pcR   [DEPTH];
    logic [63:0]      r_pcW   [DEPTH];

    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [CNT_W-1:0] r_count;

    logic [PTR_W-1:0] w_rdPtr1;
    logic [PTR_W-1:0] w_wrPtr1;
    logic             w_stall;
    logic             w_inValid0;
    logic             w_inValid1;
    logic             w_pushEn;
    logic             w_bypass;
    logic             w_bypassConsume;
    logic             w_wr0;
    logic             w_wr1;
    logic [1:0]       w_pushCnt;
    logic             w_qValid0;
    logic             w_qValid1;
    logic [1:0]       w_popCnt;

    assign w_rdPtr1 = r_rdPtr + 1'b1;
    assign w_wrPtr1 = r_wrPtr + 1'b1;

    // Stall depends only on registered occupancy, so room for a full pair is guaranteed when low.
    assign w_stall = (r_count > STALL_LEVEL);
    assign o_stall = w_stall;

    // The illegal pattern 10 carries no slot-0 instruction and is dropped entirely.
    assign w_inValid0 = i_valid[0];
    assign w_inValid1 = i_valid[0] & i_valid[1];
    assign w_pushEn   = !w_stall && !i_flush;

`ifdef WARP_IQ_BYPASS_EN
    assign w_bypass = (r_count == '0) && !i_flush && w_inValid0;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_bypassConsume = w_bypass && !i_stall;
    assign w_wr0     = w_pushEn && w_inValid0 && !w_bypassConsume;
    assign w_wr1     = w_pushEn && w_inValid1 && !w_bypassConsume;
    assign w_pushCnt = {1'b0, w_wr0} + {1'b0, w_wr1};

    assign w_qValid0 = (r_count != '0) && !i_flush;
    assign w_qValid1 = (r_count >= CNT_TWO) && !i_flush;
    assign w_popCnt  = (!i_stall && !i_flush) ? ({1'b0, w_qValid0} + {1'b0, w_qValid1}) : 2'd0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            r_wrPtr <= r_wrPtr + PTR_W'(w_pushCnt);
            r_rdPtr <= r_rdPtr + PTR_W'(w_popCnt);
            r_count <= r_count + CNT_W'(w_pushCnt) - CNT_W'(w_popCnt);
        end
    end

    // Entry payload needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge i_clk) begin
        if (w_wr0) begin
            r_inst[r_wrPtr] <= i_inst0;
            r_comp[r_wrPtr] <= i_compressed[0];
            r_pcR[r_wrPtr]  <= i_inst0_pc_rdata;
            r_pcW[r_wrPtr]  <= i_inst0_pc_wdata;
        end
        if (w_wr1) begin
            r_inst[w_wrPtr1] <= i_inst1;
            r_comp[w_wrPtr1] <= i_compressed[1];
            r_pcR[w_wrPtr1]  <= i_inst1_pc_rdata;
            r_pcW[w_wrPtr1]  <= i_inst1_pc_wdata;
        end
    end

    always_comb begin
        o_valid          = 2'b00;
        o_inst0          = CANONICAL_NOP;
        o_inst1          = CANONICAL_NOP;
        o_compressed     = 2'b00;
        o_inst0_pc_rdata = 64'd0;
        o_inst0_pc_wdata = 64'd0;
        o_inst1_pc_rdata = 64'd0;
        o_inst1_pc_wdata = 64'd0;
        if (w_bypass) begin
            o_valid[0]       = 1'b1;
            o_inst0          = i_inst0;
            o_compressed[0]  = i_compressed[0];
            o_inst0_pc_rdata = i_inst0_pc_rdata;
            o_inst0_pc_wdata = i_inst0_pc_wdata;
            if (w_inValid1) begin
                o_valid[1]       = 1'b1;
                o_inst1          = i_inst1;
                o_compressed[1]  = i_compressed[1];
                o_inst1_pc_rdata = i_inst1_pc_rdata;
                o_inst1_pc_wdata = i_inst1_pc_wdata;
            end
        end else begin
            if (w_qValid0) begin
                o_valid[0]       = 1'b1;
                o_inst0          = r_inst[r_rdPtr];
                o_compressed[0]  = r_comp[r_rdPtr];
                o_inst0_pc_rdata = r_pcR[r_rdPtr];
                o_inst0_pc_wdata = r_pcW[r_rdPtr];
            end
            if (w_qValid1) begin
                o_valid[1]       = 1'b1;
                o_inst1          = r_inst[w_rdPtr1];
                o_compressed[1]  = r_comp[w_rdPtr1];
                o_inst1_pc_rdata = r_pcR[w_rdPtr1];
                o_inst1_pc_wdata = r_pcW[w_rdPtr1];
            end
        end
    end

endmodule

// File: tb/tb_warp_inst_queue.sv
// Randomized scoreboard bench for warp_inst_queue against a queue-based reference model.
// Honours WARP_IQ_BYPASS_EN in the same way as the design.
module tb_warp_inst_queue;

    localparam int          DEPTH = 8;
    localparam logic [31:0] NOP   = 32'h00000013;

    typedef struct {
        logic [31:0] inst;
        logic        comp;
        logic [63:0] pcR;
        logic [63:0] pcW;
    } entry_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [1:0]  i_valid = 2'b00;
    logic [31:0] i_inst0 = '0;
    logic [31:0] i_inst1 = '0;
    logic [1:0]  i_compressed = 2'b00;
    logic [63:0] i_inst0_pc_rdata = '0;
    logic [63:0] i_inst0_pc_wdata = '0;
    logic [63:0] i_inst1_pc_rdata = '0;
    logic [63:0] i_inst1_pc_wdata = '0;
    logic        i_flush = 1'b0;
    logic        i_stall = 1'b0;
    logic        o_stall;
    logic [1:0]  o_valid;
    logic [31:0] o_inst0;
    logic [31:0] o_inst1;
    logic [1:0]  o_compressed;
    logic [63:0] o_inst0_pc_rdata;
    logic [63:0] o_inst0_pc_wdata;
    logic [63:0] o_inst1_pc_rdata;
    logic [63:0] o_inst1_pc_wdata;

    int checkCount = 0;
    int failCount = 0;

    entry_t refQ[$];
    entry_t pendQ[$];
    bit          monEn = 1'b0;
    bit          lastAccepted = 1'b1;
    logic [1:0]  curValid = 2'b00;
    logic [63:0] pcNext = 64'h0000000000001000;

    warp_inst_queue #(.DEPTH(DEPTH)) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_valid(i_valid),
        .i_inst0(i_inst0),
        .i_inst1(i_inst1),
        .i_compressed(i_compressed),
        .i_inst0_pc_rdata(i_inst0_pc_rdata),
        .i_inst0_pc_wdata(i_inst0_pc_wdata),
        .i_inst1_pc_rdata(i_inst1_pc_rdata),
        .i_inst1_pc_wdata(i_inst1_pc_wdata),
        .o_stall(o_stall),
        .i_flush(i_flush),
        .i_stall(i_stall),
        .o_valid(o_valid),
        .o_inst0(o_inst0),
        .o_inst1(o_inst1),
        .o_compressed(o_compressed),
        .o_inst0_pc_rdata(o_inst0_pc_rdata),
        .o_inst0_pc_wdata(o_inst0_pc_wdata),
        .o_inst1_pc_rdata(o_inst1_pc_rdata),
        .o_inst1_pc_wdata(o_inst1_pc_wdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rstValid", {62'd0, o_valid}, 64'd0);
        checkOutput("rstStall", {63'd0, o_stall}, 64'd0);
        checkOutput("rstInst0", {32'd0, o_inst0}, {32'd0, NOP});
        checkOutput("rstInst1", {32'd0, o_inst1}, {32'd0, NOP});
        checkOutput("rstComp", {62'd0, o_compressed}, 64'd0);
        checkOutput("rstPc0", o_inst0_pc_rdata | o_inst0_pc_wdata, 64'd0);
        checkOutput("rstPc1", o_inst1_pc_rdata | o_inst1_pc_wdata, 64'd0);
    endtask

    // Fetch model: holds its presented pair until the queue model says it was taken.
    task automatic applyStimulus(input logic [1:0] v, input logic st, input logic fl, input bit fixedComp);
        logic c0, c1;
        entry_t e;
        @(negedge i_clk);
        if (lastAccepted) begin
            curValid = v;
            c0 = fixedComp ? 1'b0 : 1'($urandom_range(0, 1));
            c1 = fixedComp ? 1'b0 : 1'($urandom_range(0, 1));
            i_inst0 = $urandom;
            i_inst1 = $urandom;
            i_compressed = {c1, c0};
            i_inst0_pc_rdata = pcNext;
            i_inst0_pc_wdata = pcNext + (c0 ? 64'd2 : 64'd4);
            i_inst1_pc_rdata = i_inst0_pc_wdata;
            i_inst1_pc_wdata = i_inst0_pc_wdata + (c1 ? 64'd2 : 64'd4);
            if (v == 2'b01) pcNext = i_inst0_pc_wdata;
            else if (v == 2'b11) pcNext = i_inst1_pc_wdata;
        end
        i_valid = curValid;
        i_stall = st;
        i_flush = fl;
        pendQ.delete();
        if (curValid[0]) begin
            e.inst = i_inst0; e.comp = i_compressed[0];
            e.pcR = i_inst0_pc_rdata; e.pcW = i_inst0_pc_wdata;
            pendQ.push_back(e);
            if (curValid[1]) begin
                e.inst = i_inst1; e.comp = i_compressed[1];
                e.pcR = i_inst1_pc_rdata; e.pcW = i_inst1_pc_wdata;
                pendQ.push_back(e);
            end
        end
    endtask

    task automatic doReset(input bit midRun);
        if (midRun) begin
            @(posedge i_clk);
            #2;
        end
        monEn = 1'b0;
        i_valid = 2'b00;
        i_flush = 1'b0;
        i_stall = 1'b0;
        i_rst_n = 1'b0;
        #1;
        checkResetOutputs();
        @(negedge i_clk);
        refQ.delete();
        pendQ.delete();
        lastAccepted = 1'b1;
        curValid = 2'b00;
        i_rst_n = 1'b1;
        monEn = 1'b1;
    endtask

    // Monitor: compares what decode sees against the model, then retires and admits entries.
    initial begin
        forever begin
            int n, nExp;
            bit accept, byp;
            entry_t e0, e1;
            logic [1:0] expValid;
            @(negedge i_clk);
            #1;
            if (monEn) begin
                n = refQ.size();
                checkOutput("stall", {63'd0, o_stall}, {63'd0, (n > DEPTH - 2)});
                accept = (n <= DEPTH - 2) && !i_flush;
                byp = 1'b0;
`ifdef WARP_IQ_BYPASS_EN
                byp = (n == 0) && !i_flush && (pendQ.size() > 0);
`endif
                nExp = 0;
                if (i_flush) nExp = 0;
                else if (byp) begin
                    nExp = pendQ.size();
                    e0 = pendQ[0];
                    if (nExp > 1) e1 = pendQ[1];
                end else begin
                    nExp = (n > 2) ? 2 : n;
                    if (n > 0) e0 = refQ[0];
                    if (n > 1) e1 = refQ[1];
                end
                expValid = (nExp == 2) ? 2'b11 : (nExp == 1) ? 2'b01 : 2'b00;
                checkOutput("valid", {62'd0, o_valid}, {62'd0, expValid});
                if (nExp >= 1) begin
                    checkOutput("inst0", {32'd0, o_inst0}, {32'd0, e0.inst});
                    checkOutput("comp0", {63'd0, o_compressed[0]}, {63'd0, e0.comp});
                    checkOutput("pc0Rdata", o_inst0_pc_rdata, e0.pcR);
                    checkOutput("pc0Wdata", o_inst0_pc_wdata, e0.pcW);
                end else begin
                    checkOutput("nop0", {32'd0, o_inst0}, {32'd0, NOP});
                    checkOutput("zero0", {63'd0, o_compressed[0]} | o_inst0_pc_rdata | o_inst0_pc_wdata, 64'd0);
                end
                if (nExp >= 2) begin
                    checkOutput("inst1", {32'd0, o_inst1}, {32'd0, e1.inst});
                    checkOutput("comp1", {63'd0, o_compressed[1]}, {63'd0, e1.comp});
                    checkOutput("pc1Rdata", o_inst1_pc_rdata, e1.pcR);
                    checkOutput("pc1Wdata", o_inst1_pc_wdata, e1.pcW);
                end else begin
                    checkOutput("nop1", {32'd0, o_inst1}, {32'd0, NOP});
                    checkOutput("zero1", {63'd0, o_compressed[1]} | o_inst1_pc_rdata | o_inst1_pc_wdata, 64'd0);
                end
                if (i_flush) begin
                    refQ.delete();
                end else begin
                    if (!byp && !i_stall) begin
                        for (int k = 0; k < nExp; k++) void'(refQ.pop_front());
                    end
                    if (accept && !(byp && !i_stall)) begin
                        foreach (pendQ[k]) refQ.push_back(pendQ[k]);
                    end
                end
                lastAccepted = accept || i_flush;
                pendQ.delete();
            end
        end
    end

    initial begin
        logic [1:0] v;
        int r;
        logic st, fl;
        repeat (2) @(negedge i_clk);
        doReset(1'b0);

        pcNext = 64'h8000000000000000;
        applyStimulus(2'b11, 1'b0, 1'b0, 1'b1);
        repeat (3) applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);

        repeat (6) applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
        repeat (8) applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);

        applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b11, 1'b1, 1'b1, 1'b0);
        applyStimulus(2'b11, 1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);

        repeat (3) applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus((i % 2 == 0) ? 2'b01 : 2'b11, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            v = (r < 5) ? 2'b10 : (r < 30) ? 2'b00 : (r < 60) ? 2'b01 : 2'b11;
            st = ($urandom_range(0, 99) < 35);
            fl = ($urandom_range(0, 99) < 3);
            applyStimulus(v, st, fl, 1'b0);
        end

        repeat (5) applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
        doReset(1'b1);
        for (int i = 0; i < 60; i++) begin
            applyStimulus(2'($urandom_range(0, 3) == 0 ? 0 : 2'b11), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        repeat (10) applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);

        @(negedge i_clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
